apb_clk_ctrl_regs: RTL and testbench

Parametrised APB register block for clock control, generalising the fixed CPU/AXI/APB/I2C/IMP clock registers to NUM_CH channels. Each channel has its own divider, toggle, clock-enable and ICG fields. A divider change is applied through a hardware glitch-safe sequence: gate off, wait for acknowledge or timeout, load the divider, settle, then un-gate. It sits on the AXI-to-APB bridge at SOC_MEM_MAP_AXI_APB_START_ADDR and drives the clock generator.

---
 rtl/apb_clk_ctrl_regs.sv | 240 ++++++++++++++++++++++++
 tb/tb_apb_clk_ctrl_regs.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_clk_ctrl_regs.sv
// apb_clk_ctrl_regs: APB clock-control register block with a glitch-safe divider-change sequencer
module apb_clk_ctrl_regs #(
    parameter int          NUM_CH         = 5,
    parameter int          DIV_WIDTH      = 4,
    parameter int          APB_ADDR_WIDTH = 32,
    parameter int          APB_DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h0011_0000,
    parameter int          SETTLE_CYCLES  = 4,
    parameter int          ACK_TIMEOUT    = 64,
    parameter int          DIV_RST        = 0
) (
    input  logic                          p_clk,
    input  logic                          p_rst_n,
    input  logic [APB_ADDR_WIDTH-1:0]     apb_reg_paddr,
    input  logic [2:0]                    apb_reg_pprot,
    input  logic                          apb_reg_psel,
    input  logic                          apb_reg_penable,
    input  logic                          apb_reg_pwrite,
    input  logic [APB_DATA_WIDTH-1:0]     apb_reg_pwdata,
    input  logic [3:0]                    apb_reg_pstrb,
    output logic                          apb_reg_pready,
    output logic [APB_DATA_WIDTH-1:0]     apb_reg_prdata,
    output logic                          apb_reg_pslverr,
    input  logic [NUM_CH-1:0]             clk_off_ack_i,
    output logic [NUM_CH*DIV_WIDTH-1:0]   reg_clk_div_o,
    output logic [NUM_CH-1:0]             reg_clk_tog_o,
    output logic [NUM_CH-1:0]             reg_clk_cken_o,
    output logic [NUM_CH-1:0]             reg_icg_on_o,
    output logic                          irq_o
);

    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = APB_ADDR_WIDTH - 2;
    localparam int TMAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GATE     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_SETTLE   = 3'd4;
    localparam logic [2:0] S_UNGATE   = 3'd5;

    logic [APB_ADDR_WIDTH-1:0] off;
    logic [AW-1:0]             widx;
    logic [AW-1:0]             ch_full;
    logic [CW-1:0]             ch;
    logic [CW-1:0]             first;
    logic                      is_status, is_err, is_ie, is_cfg, mapped;
    logic                      acc, bad, wr_ok;
    logic [31:0]               wmask;
    logic [APB_DATA_WIDTH-1:0] rdata;

    logic [DIV_WIDTH-1:0] div_req_q [NUM_CH];
    logic [DIV_WIDTH-1:0] div_req_d [NUM_CH];
    logic [DIV_WIDTH-1:0] div_out_q [NUM_CH];
    logic [DIV_WIDTH-1:0] div_out_d [NUM_CH];
    logic [NUM_CH-1:0]    tog_q, tog_d;
    logic [NUM_CH-1:0]    cken_q, cken_d;
    logic [NUM_CH-1:0]    icg_q, icg_d;
    logic [NUM_CH-1:0]    ie_q, ie_d;
    logic [NUM_CH-1:0]    err_q, err_d;
    logic [NUM_CH-1:0]    pend_q, pend_d;
    logic [NUM_CH-1:0]    ack_s1_q, ack_s2_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cur_q, cur_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 gate_q, gate_d;
    logic                 unused_ok;

    // Address decode and APB error qualification; paddr[1:0] is dropped before decoding
    always_comb begin
        off       = {apb_reg_paddr[APB_ADDR_WIDTH-1:2], 2'b00} - APB_ADDR_WIDTH'(BASE_ADDR);
        widx      = off[APB_ADDR_WIDTH-1:2];
        ch_full   = widx - AW'(4);
        ch        = ch_full[CW-1:0];
        is_status = widx == AW'(0);
        is_err    = widx == AW'(1);
        is_ie     = widx == AW'(2);
        is_cfg    = (widx >= AW'(4)) && (widx < AW'(4 + NUM_CH));
        mapped    = is_status || is_err || is_ie || is_cfg;
        acc       = apb_reg_psel && apb_reg_penable;
        bad       = !mapped || (apb_reg_pwrite && (is_status || (is_cfg && pend_q[ch])));
        wr_ok     = acc && apb_reg_pwrite && !bad;
        wmask     = {{8{apb_reg_pstrb[3]}}, {8{apb_reg_pstrb[2]}},
                     {8{apb_reg_pstrb[1]}}, {8{apb_reg_pstrb[0]}}};
    end

    // Read-data mux; unmapped addresses return zero
    always_comb begin
        rdata = '0;
        if (is_status)
            rdata = APB_DATA_WIDTH'(pend_q);
        else if (is_err)
            rdata = APB_DATA_WIDTH'(err_q);
        else if (is_ie)
            rdata = APB_DATA_WIDTH'(ie_q);
        else if (is_cfg) begin
            rdata[DIV_WIDTH-1:0] = div_req_q[ch];
            rdata[8]             = tog_q[ch];
            rdata[9]             = cken_q[ch];
            rdata[10]            = icg_q[ch];
        end
    end

    assign apb_reg_prdata  = rdata;
    assign apb_reg_pslverr = acc && bad;
    assign apb_reg_pready  = 1'b1;
    assign irq_o           = |(err_q & ie_q);
    assign reg_clk_tog_o   = tog_q;
    assign reg_clk_cken_o  = cken_q;

    // Lowest-index pending channel is the next one to be sequenced
    always_comb begin
        first = '0;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (pend_q[c]) first = CW'(c);
    end

    // Register writes followed by the sequencer, so a timeout set overrides a same-cycle W1C
    always_comb begin
        div_req_d = div_req_q;
        div_out_d = div_out_q;
        tog_d     = tog_q;
        cken_d    = cken_q;
        icg_d     = icg_q;
        ie_d      = ie_q;
        err_d     = err_q;
        pend_d    = pend_q;
        state_d   = state_q;
        cur_d     = cur_q;
        timer_d   = timer_q;
        gate_d    = gate_q;
        if (wr_ok && is_err)
            err_d = err_q & ~(apb_reg_pwdata[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
        if (wr_ok && is_ie)
            ie_d = (ie_q & ~wmask[NUM_CH-1:0]) | (apb_reg_pwdata[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
        if (wr_ok && is_cfg) begin
            if (apb_reg_pstrb[0]) begin
                div_req_d[ch] = apb_reg_pwdata[DIV_WIDTH-1:0];
                pend_d[ch]    = 1'b1;
            end
            if (apb_reg_pstrb[1]) begin
                tog_d[ch]  = apb_reg_pwdata[8];
                cken_d[ch] = apb_reg_pwdata[9];
                icg_d[ch]  = apb_reg_pwdata[10];
            end
        end
        case (state_q)
            S_IDLE: if (|pend_q) begin
                cur_d   = first;
                gate_d  = 1'b1;
                state_d = S_GATE;
            end
            S_GATE: begin
                timer_d = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: if (ack_s2_q[cur_q])
                state_d = S_LOAD;
            else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                err_d[cur_q] = 1'b1;
                state_d      = S_LOAD;
            end else
                timer_d = timer_q + TW'(1);
            S_LOAD: begin
                div_out_d[cur_q] = div_req_q[cur_q];
                timer_d          = '0;
                state_d          = S_SETTLE;
            end
            S_SETTLE: if (timer_q == TW'(SETTLE_CYCLES - 1))
                state_d = S_UNGATE;
            else
                timer_d = timer_q + TW'(1);
            S_UNGATE: begin
                gate_d        = 1'b0;
                pend_d[cur_q] = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset leaves every channel ungated at the reset divider
    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                div_req_q[c] <= DIV_WIDTH'(DIV_RST);
                div_out_q[c] <= DIV_WIDTH'(DIV_RST);
            end
            tog_q   <= '1;
            cken_q  <= '1;
            icg_q   <= '1;
            ie_q    <= '0;
            err_q   <= '0;
            pend_q  <= '0;
            state_q <= S_IDLE;
            cur_q   <= '0;
            timer_q <= '0;
            gate_q  <= 1'b0;
        end else begin
            div_req_q <= div_req_d;
            div_out_q <= div_out_d;
            tog_q     <= tog_d;
            cken_q    <= cken_d;
            icg_q     <= icg_d;
            ie_q      <= ie_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            cur_q     <= cur_d;
            timer_q   <= timer_d;
            gate_q    <= gate_d;
        end
    end

    // Two-flop synchroniser for the asynchronous clock-stopped acknowledges
    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            ack_s1_q <= '0;
            ack_s2_q <= '0;
        end else begin
            ack_s1_q <= clk_off_ack_i;
            ack_s2_q <= ack_s1_q;
        end
    end

    // Effective outputs: the sequencer gate masks the software ICG enable of the active channel
    always_comb begin
        reg_clk_div_o = '0;
        reg_icg_on_o  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            reg_clk_div_o[c*DIV_WIDTH +: DIV_WIDTH] = div_out_q[c];
            reg_icg_on_o[c] = icg_q[c] & ~(gate_q && (cur_q == CW'(c)));
        end
    end

    assign unused_ok = ^{apb_reg_pprot, apb_reg_paddr, apb_reg_pwdata, wmask, off, ch_full};

endmodule

// File: tb/tb_apb_clk_ctrl_regs.sv
// tb_apb_clk_ctrl_regs: table-driven and sequence checks of the clock-control register block
module tb_apb_clk_ctrl_regs;

    localparam int          NCH    = 5;
    localparam int          DW     = 4;
    localparam int          SETTLE = 4;
    localparam int          TOUT   = 64;
    localparam logic [31:0] BASE   = 32'h0011_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     paddr = '0;
    logic [2:0]      pprot = '0;
    logic            psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]     pwdata = '0;
    logic [3:0]      pstrb = '0;
    logic            pready;
    logic [31:0]     prdata;
    logic            pslverr;
    logic [NCH-1:0]  ack = '1;
    logic [NCH*DW-1:0] div_o;
    logic [NCH-1:0]  tog_o, cken_o, icg_o;
    logic            irq;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    apb_clk_ctrl_regs dut (
        .p_clk           (clk),
        .p_rst_n         (rst_n),
        .apb_reg_paddr   (paddr),
        .apb_reg_pprot   (pprot),
        .apb_reg_psel    (psel),
        .apb_reg_penable (penable),
        .apb_reg_pwrite  (pwrite),
        .apb_reg_pwdata  (pwdata),
        .apb_reg_pstrb   (pstrb),
        .apb_reg_pready  (pready),
        .apb_reg_prdata  (prdata),
        .apb_reg_pslverr (pslverr),
        .clk_off_ack_i   (ack),
        .reg_clk_div_o   (div_o),
        .reg_clk_tog_o   (tog_o),
        .reg_clk_cken_o  (cken_o),
        .reg_icg_on_o    (icg_o),
        .irq_o           (irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [3:0] div_of(input int c);
        return div_o[c*DW +: DW];
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that completes the access
    task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic er);
        paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        #3 rd = prdata; er = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] erd, input logic eerr);
        exp_t e;
        logic [31:0] rd;
        logic er;
        sb.push_back('{erd, eerr, !w});
        apb(a, w, d, s, rd, er);
        e = sb.pop_front();
        if (e.chk_rd) chk($sformatf("rdata@%0h", a), rd, e.rd);
        chk($sformatf("pslverr@%0h%s", a, w ? "/wr" : "/rd"), 32'(er), 32'(e.err));
    endtask

    // Follows one channel's sequence: gate samples before the divider changes, and gate cycles after
    task automatic watch(input int c, input logic [3:0] exp_div, input string nm, output int low_before);
        int  low_after = 0;
        bit  changed = 0;
        bit  done = 0;
        low_before = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!changed && div_of(c) == exp_div) changed = 1;
            if (!icg_o[c]) begin
                if (changed) low_after++;
                else low_before++;
            end else if (changed) done = 1;
        end
        chk({nm, " seq_done"}, 32'(done), 32'd1);
        chk({nm, " gate_before_div"}, 32'(low_before > 0), 32'd1);
        chk({nm, " gate_cycles_after_div"}, 32'(low_after), 32'(SETTLE + 1));
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        int   lb, overlap, f0, f4;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst icg_on", 32'(icg_o), 32'h1F);
        chk("rst tog", 32'(tog_o), 32'h1F);
        chk("rst cken", 32'(cken_o), 32'h1F);
        chk("rst div", 32'(div_o), 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        chk("pready", 32'(pready), 32'h1);

        vt.push_back('{BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0});
        for (int c = 0; c < NCH; c++)
            vt.push_back('{BASE + 32'h10 + 32'(4*c), 1'b0, 32'h0, 4'hF, 32'h700, 1'b0});
        vt.push_back('{BASE + 32'h04, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back('{BASE + 32'h08, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back('{BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1});
        vt.push_back('{BASE + 32'h24, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1});
        vt.push_back('{BASE + 32'h50, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1});
        vt.push_back('{BASE - 32'h04, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1});
        vt.push_back('{BASE + 32'h00, 1'b1, 32'hFF, 4'hF, 32'h0, 1'b1});
        vt.push_back('{BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back('{BASE + 32'h50, 1'b1, 32'h1, 4'hF, 32'h0, 1'b1});
        vt.push_back('{BASE + 32'h1C, 1'b1, 32'h0000_0005, 4'b0010, 32'h0, 1'b0});
        vt.push_back('{BASE + 32'h1C, 1'b0, 32'h0, 4'hF, 32'h000, 1'b0});
        vt.push_back('{BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back('{BASE + 32'h08, 1'b1, 32'hFF, 4'b0001, 32'h0, 1'b0});
        vt.push_back('{BASE + 32'h08, 1'b0, 32'h0, 4'hF, 32'h1F, 1'b0});
        vt.push_back('{BASE + 32'h08, 1'b1, 32'h0, 4'b0010, 32'h0, 1'b0});
        vt.push_back('{BASE + 32'h08, 1'b0, 32'h0, 4'hF, 32'h1F, 1'b0});
        vt.push_back('{BASE + 32'h08, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back('{BASE + 32'h13, 1'b0, 32'h0, 4'hF, 32'h700, 1'b0});
        foreach (vt[i])
            xfer(vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].strb, vt[i].rd, vt[i].err);

        chk("partial icg_on", 32'(icg_o), 32'h17);
        chk("partial tog", 32'(tog_o), 32'h17);
        chk("partial cken", 32'(cken_o), 32'h17);
        chk("partial div", 32'(div_o), 32'h0);
        xfer(BASE + 32'h1C, 1'b1, 32'h700, 4'b0010, 32'h0, 1'b0);
        chk("restore icg_on", 32'(icg_o), 32'h1F);

        xfer(BASE + 32'h18, 1'b1, 32'h705, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h4, 1'b0);
        watch(2, 4'd5, "t2", lb);
        xfer(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        chk("t2 div2", 32'(div_of(2)), 32'h5);

        ack[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        xfer(BASE + 32'h14, 1'b1, 32'h703, 4'hF, 32'h0, 1'b0);
        watch(1, 4'd3, "t3", lb);
        chk("t3 timeout gate samples", 32'(lb), 32'(TOUT + 2));
        @(posedge clk);
        #1;
        xfer(BASE + 32'h04, 1'b0, 32'h0, 4'hF, 32'h2, 1'b0);
        chk("t3 irq masked", 32'(irq), 32'h0);
        xfer(BASE + 32'h08, 1'b1, 32'h2, 4'hF, 32'h0, 1'b0);
        chk("t3 irq set", 32'(irq), 32'h1);
        xfer(BASE + 32'h04, 1'b1, 32'h2, 4'hF, 32'h0, 1'b0);
        chk("t3 irq cleared", 32'(irq), 32'h0);
        xfer(BASE + 32'h04, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        ack[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        overlap = 0; f0 = -1; f4 = -1;
        fork
            begin
                xfer(BASE + 32'h10, 1'b1, 32'h702, 4'hF, 32'h0, 1'b0);
                xfer(BASE + 32'h20, 1'b1, 32'h709, 4'hF, 32'h0, 1'b0);
                xfer(BASE + 32'h10, 1'b1, 32'h70F, 4'hF, 32'h0, 1'b1);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (!icg_o[0] && !icg_o[4]) overlap++;
                    if (!icg_o[0] && f0 < 0) f0 = i;
                    if (!icg_o[4] && f4 < 0) f4 = i;
                end
            end
        join
        #1;
        chk("t4 gate overlap", 32'(overlap), 32'h0);
        chk("t4 ch0 before ch4", 32'(f0 >= 0 && f4 > f0), 32'h1);
        chk("t4 div0", 32'(div_of(0)), 32'h2);
        chk("t4 div4", 32'(div_of(4)), 32'h9);
        @(posedge clk);
        #1;
        xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 32'h702, 1'b0);
        xfer(BASE + 32'h20, 1'b0, 32'h0, 4'hF, 32'h709, 1'b0);
        xfer(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);

        xfer(BASE + 32'h18, 1'b1, 32'h70A, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 100 && div_of(2) != 4'hA; i++) @(negedge clk);
        chk("t6 div2 loaded", 32'(div_of(2)), 32'hA);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst icg_on", 32'(icg_o), 32'h1F);
        chk("t6 rst div", 32'(div_o), 32'h0);
        chk("t6 rst tog", 32'(tog_o), 32'h1F);
        chk("t6 rst irq", 32'(irq), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        xfer(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h18, 1'b0, 32'h0, 4'hF, 32'h700, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t6 no stale icg_on", 32'(icg_o), 32'h1F);
        chk("t6 no stale div", 32'(div_o), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
